instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the Controller in the multicycle ARM core.
//  Holds the PC, issues one instruction-memory read at a time and captures the word in an instruction register.
//  Presents cond/op/funct/rd fields plus PC to the Controller and datapath.
//  Consumes the Controller's pc_src decision to redirect the next fetch.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be word aligned
//  ADDR_W     32             PC / imem address width
// PORTS
//  clk            in   1       core clock; all state updates on posedge
//  reset          in   1       synchronous, active-high reset
//  imem_req       out  1       read request; held high until imem_ack
//  imem_addr      out  ADDR_W  word-aligned read address; stable while imem_req=1
//  imem_ack       in   1       read data valid this cycle (latency >=0 cycles after req)
//  imem_rdata     in   32      instruction word, sampled when imem_req & imem_ack
//  instr_valid    out  1       instr/pc outputs hold a fetched instruction
//  instr_ready    in   1       downstream consumes the instruction this cycle
//  branch_taken   in   1       Controller pc_src; sampled only on consume
//  branch_target  in   ADDR_W  redirect address; sampled with branch_taken
//  instr          out  32      instruction register
//  cond           out  4       instr[31:28]
//  op             out  2       instr[27:26]
//  funct          out  6       instr[25:20]
//  rd             out  4       instr[15:12]
//  pc             out  ADDR_W  address of instr
//  pc_plus8       out  ADDR_W  pc+8 (architectural R15 read value)
//  fetch_fault    out  1       sticky: misaligned branch_target seen
// BEHAVIOUR
//  FSM states: IDLE, REQ, HOLD, FAULT.
//  Reset (sync):
//   - state=IDLE, next_pc=RESET_PC.
//   - imem_req=0, instr_valid=0, instr=0, pc=RESET_PC, fetch_fault=0.
//   - Reset asserted mid-request abandons it; an imem_ack arriving in IDLE is ignored.
//  IDLE: next cycle -> REQ. imem_req=0.
//  REQ:
//   - imem_req=1, imem_addr=next_pc.
//   - On imem_ack: instr<=imem_rdata, pc<=next_pc -> HOLD.
//   - Otherwise stay, address unchanged.
//  HOLD:
//   - instr_valid=1; outputs stable until consumed.
//   - On instr_ready:
//     - if branch_taken: next_pc<=branch_target, else next_pc<=pc+4.
//     - Then -> REQ; instr_valid drops the cycle after consume.
//  Misaligned redirect:
//   - Condition: consume with branch_taken=1 and branch_target[1:0]!=0.
//   - Action: fetch_fault<=1 -> FAULT.
//  FAULT: imem_req=0, instr_valid=0; held until reset.
//  Throughput: best case 1 instr per 2 cycles (ack same cycle as req).
//  Only one request outstanding; imem_ack while imem_req=0 is ignored.
//  Arithmetic: pc+4 and pc+8 are modulo 2^ADDR_W (0xFFFF_FFFC+4 wraps to 0).
//  Field outputs are combinational slices of instr; they are only meaningful when instr_valid=1.
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: adds two ports.
//   - fetch_count out 32: increments on each imem_ack accepted in REQ.
//   - stall_count out 32: increments each HOLD cycle with instr_ready=0.
//   - Both reset to 0 and wrap at 2^32.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  Reset then ack immediately -> imem_addr=0x0 and instr_valid=1 two cycles after reset deasserts; pc=0, pc_plus8=8.
//  rdata=0xE2811002, ack after 3 wait cycles -> imem_req/addr stable 4 cycles; cond=0xE, op=0, funct=0x28, rd=1.
//  HOLD with instr_ready=0 for 5 cycles -> instr/pc unchanged, no new imem_req; then ready -> next addr pc+4.
//  Consume with branch_taken=1, target=0x100 -> next imem_addr=0x100; target=0x102 -> fetch_fault=1, imem_req stays 0.
//  Reset asserted while REQ pending, ack arrives next cycle -> ignored; refetch from RESET_PC.
//  IFU_PERF_CNT_EN: 3 fetches and 4 stall cycles -> fetch_count=3, stall_count=4.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one imem read at a time, captures the instruction.
// Optional perf counters (fetch_count, stall_count) enabled by IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       instr,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus8,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count,
`endif
  output logic              fetch_fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    FAULT
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] next_pc_q;
  logic [ADDR_W-1:0] next_pc_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic              req_q;
  logic              valid_q;
  logic              fault_q;
  logic              misalign;

  always_comb begin
    next_pc_d = branch_taken ? branch_target
                             : pc_q + ADDR_W'(4);
    misalign  = branch_taken &&
                (branch_target[1:0] != 2'b00);
  end

  // Outputs are registered alongside the state so they change only on edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      next_pc_q <= RESET_PC;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            pc_q    <= next_pc_q;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            if (misalign) begin
              fault_q <= 1'b1;
              state_q <= FAULT;
            end else begin
              next_pc_q <= next_pc_d;
              req_q     <= 1'b1;
              state_q   <= REQ;
            end
          end
        end
        FAULT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == REQ && imem_ack)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == HOLD && !instr_ready)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = next_pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign cond        = instr_q[31:28];
  assign op          = instr_q[27:26];
  assign funct       = instr_q[25:20];
  assign rd          = instr_q[15:12];
  assign pc          = pc_q;
  assign pc_plus8    = pc_q + ADDR_W'(8);
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetch/consume
// traffic checked against an address/instruction reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .cond          (cond),
    .op            (op),
    .funct         (funct),
    .rd            (rd),
    .pc            (pc),
    .pc_plus8      (pc_plus8),
`ifdef IFU_PERF_CNT_EN
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
`endif
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_data;
  int          n_fetch;
  int          n_stall;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_fcnt", fetch_count, 32'd0);
    chk("rst_scnt", stall_count, 32'd0);
`endif
    reset = 1'b0;
    exp_pc = 32'h0;
    n_fetch = 0;
    n_stall = 0;
  endtask

  task automatic fetch(input int w, input logic [31:0] data,
                       output int lat);
    lat = 0;
    while (imem_req !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    for (int i = 0; i < w; i++) begin
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      @(negedge clk);
    end
    chk("ack_req", {31'b0, imem_req}, 32'd1);
    chk("ack_addr", imem_addr, exp_pc);
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    n_fetch++;
    last_data = data;
    chk("f_valid", {31'b0, instr_valid}, 32'd1);
    chk("f_req_low", {31'b0, imem_req}, 32'd0);
    chk("f_instr", instr, data);
    chk("f_pc", pc, exp_pc);
    chk("f_pc8", pc_plus8, exp_pc + 32'd8);
    chk("f_cond", {28'b0, cond}, {28'b0, data[31:28]});
    chk("f_op", {30'b0, op}, {30'b0, data[27:26]});
    chk("f_funct", {26'b0, funct}, {26'b0, data[25:20]});
    chk("f_rd", {28'b0, rd}, {28'b0, data[15:12]});
  endtask

  task automatic consume(input int stall, input logic tk,
                         input logic [31:0] tgt);
    for (int s = 0; s < stall; s++) begin
      instr_ready = 1'b0;
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      chk("st_valid", {31'b0, instr_valid}, 32'd1);
      chk("st_req", {31'b0, imem_req}, 32'd0);
      chk("st_instr", instr, last_data);
      chk("st_pc", pc, exp_pc);
      @(negedge clk);
      n_stall++;
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1;
    branch_taken = tk;
    branch_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    chk("c_valid", {31'b0, instr_valid}, 32'd0);
    if (tk && tgt[1:0] != 2'b00) begin
      chk("c_fault", {31'b0, fetch_fault}, 32'd1);
      chk("c_fault_req", {31'b0, imem_req}, 32'd0);
    end else begin
      exp_pc = tk ? tgt : exp_pc + 32'd4;
      chk("c_req", {31'b0, imem_req}, 32'd1);
      chk("c_addr", imem_addr, exp_pc);
      chk("c_nofault", {31'b0, fetch_fault}, 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] tgt;
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    last_data = '0;

    do_reset();
    fetch(0, 32'hE3A00001, lat);
    chk("first_lat", lat, 32'd1);
    consume(0, 1'b0, 32'h0);
    fetch(3, 32'hE2811002, lat);
    chk("dir_cond", {28'b0, cond}, 32'hE);
    chk("dir_funct", {26'b0, funct}, 32'h28);
    chk("dir_rd", {28'b0, rd}, 32'h1);
    consume(5, 1'b0, 32'h0);
    fetch(1, 32'hE1A0F00E, lat);
    consume(0, 1'b1, 32'h100);
    fetch(0, 32'hEAFFFFFE, lat);
    consume(0, 1'b1, 32'hFFFF_FFFC);
    fetch(0, 32'hE0800001, lat);
    chk("wrap_pc8", pc_plus8, 32'h4);
    consume(0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    fetch(2, 32'hE5912000, lat);

    for (int k = 0; k < 30; k++) begin
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      consume($urandom_range(0, 2),
              1'($urandom_range(0, 3) == 0), tgt);
      fetch($urandom_range(0, 3), $urandom, lat);
    end
`ifdef IFU_PERF_CNT_EN
    chk("rand_fcnt", fetch_count, n_fetch);
    chk("rand_scnt", stall_count, n_stall);
`endif

    consume(1, 1'b1, 32'h102);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      chk("flt_req", {31'b0, imem_req}, 32'd0);
      chk("flt_valid", {31'b0, instr_valid}, 32'd0);
      chk("flt_sticky", {31'b0, fetch_fault}, 32'd1);
    end
    imem_ack = 1'b0;

    do_reset();
    @(negedge clk);
    chk("mid_req", {31'b0, imem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mid_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_instr", instr, 32'd0);
    chk("mid_req2", {31'b0, imem_req}, 32'd1);
    chk("mid_addr", imem_addr, 32'h0);
    fetch(0, 32'hE3A01005, lat);
    chk("mid_lat", lat, 32'd0);

    do_reset();
    fetch(0, 32'hE3A00001, lat);
    consume(2, 1'b0, 32'h0);
    fetch(1, 32'hE3A00002, lat);
    consume(2, 1'b0, 32'h0);
    fetch(0, 32'hE3A00003, lat);
    chk("cnt_pc", pc, 32'h8);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fcnt", fetch_count, 32'd3);
    chk("perf_scnt", stall_count, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
